// File: rtl/arb_muxn.sv
// -----------------------------------------------------------------------------
// arb_muxn
//
// Round-robin arbiter in front of a single registered output channel.
// Each cycle the first valid requester is selected, scanning from the priority
// pointer upwards with wrap-around. Its word is loaded into a one-entry output
// register whenever that register is empty or draining in the same cycle.
// After every input transfer the pointer moves to the slot just past the
// winner, so all requesters are served in turn.
//
// Parameters
//   INPUT_NUM  : number of requesters (>= 2, need not be a power of two)
//   INPUT_SIZE : data word width in bits
//   S          : width of the source index, $clog2(INPUT_NUM)
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : bit i set when requester i offers a word
//   in_data    : requester i's word in bits [INPUT_SIZE*(i+1)-1 : INPUT_SIZE*i]
//   in_ready   : one-hot or zero, bit i set when requester i's word is taken
//   out_valid  : output register holds a word
//   out_ready  : consumer accepts the output word this cycle
//   out_data   : registered word
//   out_src    : index of the requester that produced out_data
//
// Configuration
//   ARB_MUXN_FIXED_PRIO_EN : when defined, the pointer is tied to 0 so the
//                            lowest valid index always wins. Handshake,
//                            latency and reset behaviour are unchanged.
// -----------------------------------------------------------------------------
module arb_muxn #(
  parameter int  INPUT_NUM  = 4,
  parameter int  INPUT_SIZE = 8,
  localparam int S          = $clog2(INPUT_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [INPUT_NUM-1:0]            in_valid,
  input  logic [INPUT_NUM*INPUT_SIZE-1:0] in_data,
  output logic [INPUT_NUM-1:0]            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INPUT_SIZE-1:0]           out_data,
  output logic [S-1:0]                    out_src
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [S-1:0]   ptr;
  logic [S-1:0]   win;
  logic           found;
  logic [S:0]     idx;
  logic           load_ok;
  logic           take;

  // The register can accept a new word when it is empty or being drained.
  assign load_ok = (state == EMPTY) || out_ready;

  // rst_n gates the grant so no requester sees a handshake while in reset.
  assign take = found && load_ok && rst_n;

  assign out_valid = (state == FULL);

  // Winner search: scan ptr, ptr+1, ... with wrap at INPUT_NUM. The index is
  // one bit wider than S so ptr+k never overflows before the wrap correction.
  // NOTE: every variable written here gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < INPUT_NUM; k++) begin
      idx = {1'b0, ptr} + (S+1)'(k);
      if (idx >= (S+1)'(INPUT_NUM)) begin
        idx = idx - (S+1)'(INPUT_NUM);
      end
      if (!found && in_valid[idx[S-1:0]]) begin
        found = 1'b1;
        win   = idx[S-1:0];
      end
    end
  end

  // Grant depends only on valid bits, pointer and output state, never on data.
  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[win] = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (take) begin
      next_state = FULL;
    end else if ((state == FULL) && out_ready) begin
      next_state = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Payload holds its last value after a drain; only a new grant reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
    end else if (take) begin
      out_data <= in_data[win*INPUT_SIZE +: INPUT_SIZE];
      out_src  <= win;
    end
  end

`ifdef ARB_MUXN_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at requester 0.
  assign ptr = '0;
`else
  logic [S-1:0] ptr_next;

  // Explicit wrap keeps ptr inside 0..INPUT_NUM-1 for non-power-of-two sizes.
  assign ptr_next = (win == S'(INPUT_NUM - 1)) ? '0 : win + S'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= ptr_next;
    end
  end
`endif

endmodule
